if_fetch_unit: RTL

Instruction-fetch front end that produces the `IF_PCadd4` / `IF_Inst` pair consumed by the IF/ID pipeline register. It owns the program counter and talks to instruction memory over a request/ready handshake. It holds its output stable while the downstream register is stalled and squashes in-flight fetches on a branch/jump redirect. It uses the same `stall` / `stallstall` hold semantics as the IF/ID register, so the two always agree on when an instruction is consumed.

---
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready handshake,
// presents IF_Inst/IF_PCadd4 to the IF/ID register and squashes on redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        stallstall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_Inst,
    output logic [31:0] IF_PCadd4,
    output logic        IF_valid,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcadd4_q, pcadd4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;

    logic        en;
    logic [31:0] target_pc;
    logic        unused_pc_bits;

    // Same consume condition as the IF/ID register so both agree on hand-off.
    assign en             = ~stall & ~stallstall;
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        // Redirect squashes whatever is held and retargets the PC.
        if (redirect && (state_q != StIdle)) begin
            pc_d    = target_pc;
            valid_d = 1'b0;
            inst_d  = 32'h0;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                // The request is already out, so a redirect must drain it in DROP.
                state_d = redirect ? StDrop : StWait;
            end
            StWait: begin
                if (redirect) begin
                    state_d = imem_ready ? StFetch : StDrop;
                end else if (imem_ready) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect) begin
                    state_d = StFetch;
                end else if (en) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    inst_d  = 32'h0;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = StFetch;
                end
            end
            StDrop: begin
                // Stale response is discarded; the PC already points at the target.
                if (imem_ready) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pcadd4_d = pc_d + 32'd4;
        req_d    = (state_d == StFetch);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            pcadd4_q <= RESET_PC + 32'd4;
            inst_q   <= 32'h0;
            valid_q  <= 1'b0;
            cnt_q    <= 32'h0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pcadd4_q <= pcadd4_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign IF_Inst   = inst_q;
    assign IF_PCadd4 = pcadd4_q;
    assign IF_valid  = valid_q;
    assign fetch_cnt = cnt_q;

endmodule
